// File: rtl/mem_responder_pkg.sv
// Shared encodings for the CPU memory-bus responder: FSM states, request
// type and default word width.
package mem_responder_pkg;
    localparam int WORD_W_DEF = 16;

    typedef enum logic [1:0] {
        RS_IDLE = 2'd0,
        RS_WAIT = 2'd1,
        RS_RESP = 2'd2,
        RS_HOLD = 2'd3
    } rs_state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_type_e;
endpackage

// File: rtl/mem_responder_if.sv
// CPU <-> responder memory bus: level requests in, one-cycle done pulses out.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
);
    logic              read_m;
    logic              write_m;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] write_data;
    logic [WORD_W-1:0] read_data;
    logic              input_ready;
    logic              ack_output;
    logic              busy;
    logic              req_error;

    modport master (
        output read_m, write_m, address, write_data,
        input  read_data, input_ready, ack_output, busy, req_error
    );

    modport slave (
        input  read_m, write_m, address, write_data,
        output read_data, input_ready, ack_output, busy, req_error
    );
endinterface

// File: rtl/mem_responder_mem_array.sv
// DEPTH x WORD_W storage: synchronous write, asynchronous read; the single
// write port is shared by responder commits and backdoor loads.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DEPTH  = 256,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              cmt_en_i,
    input  logic [AW-1:0]     cmt_addr_i,
    input  logic [WORD_W-1:0] cmt_data_i,
    input  logic              ld_en_i,
    input  logic [AW-1:0]     ld_addr_i,
    input  logic [WORD_W-1:0] ld_data_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);
    logic [WORD_W-1:0] mem [DEPTH];
    logic              we;
    logic [AW-1:0]     waddr;
    logic [WORD_W-1:0] wdata;

    // Commit and load are mutually exclusive by construction; commit wins anyway.
    assign we    = cmt_en_i | ld_en_i;
    assign waddr = cmt_en_i ? cmt_addr_i : ld_addr_i;
    assign wdata = cmt_en_i ? cmt_data_i : ld_data_i;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rd_data_o = mem[rd_addr_i];
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle CPU: serves held read/write
// requests after LATENCY cycles, with a backdoor load port usable when idle.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WORD_W  = WORD_W_DEF,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_responder_if.slave    bus,
    input  logic              ld_en,
    input  logic [WORD_W-1:0] ld_addr,
    input  logic [WORD_W-1:0] ld_data
);
    localparam int AW = $clog2(DEPTH);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mem_responder: LATENCY must be 1..15");
        end
        if ((1 << AW) != DEPTH) begin : g_bad_depth
            $error("mem_responder: DEPTH must be a power of two");
        end
    endgenerate

    rs_state_e         state_q;
    req_type_e         type_q;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] data_q;
    logic [3:0]        cnt_q;
    logic [WORD_W-1:0] read_data_q;
    logic              input_ready_q, ack_q, err_q;

    logic              one_req, both_req, line_hi, cmt_en, ld_ok, idle;
    logic [AW-1:0]     cmt_addr;
    logic [WORD_W-1:0] cmt_data, mem_rdata;
    logic              unused_hi_bits;

    assign idle     = (state_q == RS_IDLE);
    assign one_req  = bus.read_m ^ bus.write_m;
    assign both_req = bus.read_m & bus.write_m;
    assign line_hi  = (type_q == REQ_WR) ? bus.write_m : bus.read_m;

    // Writes land on the edge that enters RESP; with LATENCY=1 that is the
    // sampling edge itself, so the live bus values are committed directly.
    assign cmt_en   = reset_n &&
                      ((idle && LATENCY == 1 && one_req && bus.write_m) ||
                       (state_q == RS_WAIT && cnt_q == 4'd1 && line_hi && type_q == REQ_WR));
    assign cmt_addr = idle ? bus.address[AW-1:0] : addr_q;
    assign cmt_data = idle ? bus.write_data : data_q;
    assign ld_ok    = reset_n && idle && !bus.read_m && !bus.write_m && ld_en;

    assign unused_hi_bits = ^{bus.address[WORD_W-1:AW], ld_addr[WORD_W-1:AW]};

    mem_array #(.WORD_W(WORD_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk        (clk),
        .cmt_en_i   (cmt_en),
        .cmt_addr_i (cmt_addr),
        .cmt_data_i (cmt_data),
        .ld_en_i    (ld_ok),
        .ld_addr_i  (ld_addr[AW-1:0]),
        .ld_data_i  (ld_data),
        .rd_addr_i  (addr_q),
        .rd_data_o  (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= RS_IDLE;
            read_data_q   <= '0;
            input_ready_q <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            input_ready_q <= 1'b0;
            ack_q         <= 1'b0;
            err_q         <= 1'b0;
            case (state_q)
                RS_IDLE: begin
                    if (both_req) begin
                        err_q <= 1'b1;
                    end else if (one_req) begin
                        type_q  <= bus.write_m ? REQ_WR : REQ_RD;
                        addr_q  <= bus.address[AW-1:0];
                        data_q  <= bus.write_data;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= (LATENCY == 1) ? RS_RESP : RS_WAIT;
                    end
                end
                RS_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (!line_hi)            state_q <= RS_IDLE;
                    else if (cnt_q == 4'd1)  state_q <= RS_RESP;
                end
                RS_RESP: begin
                    if (type_q == REQ_RD) begin
                        input_ready_q <= 1'b1;
                        read_data_q   <= mem_rdata;
                    end else begin
                        ack_q <= 1'b1;
                    end
                    // A still-held request parks in HOLD so it is not served twice.
                    state_q <= line_hi ? RS_HOLD : RS_IDLE;
                end
                RS_HOLD: begin
                    if (!bus.read_m && !bus.write_m) state_q <= RS_IDLE;
                end
                default: state_q <= RS_IDLE;
            endcase
        end
    end

    assign bus.read_data   = read_data_q;
    assign bus.input_ready = input_ready_q;
    assign bus.ack_output  = ack_q;
    assign bus.req_error   = err_q;
    assign bus.busy        = !idle;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: four responders (LATENCY 1..4) share one broadcast bus
// stimulus; each has its own expected-response queue and monitor.
module tb_mem_responder;
    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        logic         is_rd;
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         read_m = 1'b0, write_m = 1'b0, ld_en = 1'b0;
    logic [W-1:0] address = '0, write_data = '0, ld_addr = '0, ld_data = '0;

    logic [N-1:0] rdy_w, ack_w, busy_w, err_w;
    logic [W-1:0] rdat_w [N];

    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   err_cnt [N];
    exp_t exp_q [N][$];
    logic [W-1:0] mdl [N][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", nm, act, want, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : gd
        mem_responder_if #(.WORD_W(W)) bus ();
        assign bus.read_m     = read_m;
        assign bus.write_m    = write_m;
        assign bus.address    = address;
        assign bus.write_data = write_data;
        assign rdy_w[g]  = bus.input_ready;
        assign ack_w[g]  = bus.ack_output;
        assign busy_w[g] = bus.busy;
        assign err_w[g]  = bus.req_error;
        assign rdat_w[g] = bus.read_data;

        mem_responder #(.WORD_W(W), .DEPTH(256), .LATENCY(g + 1)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus.slave),
            .ld_en   (ld_en),
            .ld_addr (ld_addr),
            .ld_data (ld_data)
        );

        always @(negedge clk) begin : mon
            exp_t e;
            if (err_w[g]) err_cnt[g]++;
            if (rdy_w[g] || ack_w[g]) begin
                if (exp_q[g].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL L%0d_unexpected_pulse: got rdy=%b ack=%b expected no pulse (cyc %0d)",
                             g + 1, rdy_w[g], ack_w[g], cyc);
                end else begin
                    e = exp_q[g].pop_front();
                    chk($sformatf("L%0d_kind", g + 1), {30'd0, rdy_w[g], ack_w[g]},
                        e.is_rd ? 32'd2 : 32'd1);
                    chk($sformatf("L%0d_cycle", g + 1), cyc, e.due);
                    if (e.is_rd) chk($sformatf("L%0d_rdata", g + 1), {16'd0, rdat_w[g]}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        for (int k = 0; k < N; k++) mdl[k][a[7:0]] = d;
    endtask

    // Request held for h sampling edges; LATENCY L is served iff h >= L.
    task automatic req(input logic is_rd, input logic [W-1:0] a, input logic [W-1:0] d,
                       input int h, input logic ld = 1'b0);
        int   c0;
        exp_t e;
        c0 = cyc;
        for (int k = 0; k < N; k++) begin
            if (h >= k + 1) begin
                e.is_rd = is_rd;
                e.data  = is_rd ? mdl[k][a[7:0]] : d;
                e.due   = c0 + 2 + k;
                exp_q[k].push_back(e);
                if (!is_rd) mdl[k][a[7:0]] = d;
            end
        end
        read_m = is_rd; write_m = !is_rd; address = a; write_data = d; ld_en = ld;
        tick();
        chk("busy_after_edge0", {28'd0, busy_w}, 32'hF);
        tick(h - 1);
        ld_en = 1'b0; read_m = 1'b0; write_m = 1'b0;
        tick(2);
        chk("busy_back_idle", {28'd0, busy_w}, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < N; k++) err_cnt[k] = 0;
        tick(3);
        chk("rst_rdy", {28'd0, rdy_w}, 0);
        chk("rst_ack", {28'd0, ack_w}, 0);
        chk("rst_busy", {28'd0, busy_w}, 0);
        chk("rst_err", {28'd0, err_w}, 0);
        for (int k = 0; k < N; k++) chk("rst_rdata", {16'd0, rdat_w[k]}, 0);
        reset_n = 1'b1;
        tick();

        load(16'h0007, 16'h0000);
        load(16'h0020, 16'h1111);

        // write then read back, with held write parking in HOLD
        req(1'b0, 16'h0010, 16'hBEEF, 6);
        req(1'b1, 16'h0010, 16'h0000, 4);
        req(1'b0, 16'h0011, 16'h1234, 4);
        for (int k = 0; k < N; k++) chk("rdata_kept_over_write", {16'd0, rdat_w[k]}, 32'hBEEF);

        // abort after one sampled cycle: only LATENCY=1 had committed
        req(1'b0, 16'h0007, 16'hAAAA, 1);
        req(1'b1, 16'h0007, 16'h0000, 4);

        // conflict
        read_m = 1'b1; write_m = 1'b1; address = 16'h0003;
        tick();
        read_m = 1'b0; write_m = 1'b0;
        chk("conflict_err", {28'd0, err_w}, 32'hF);
        chk("conflict_busy", {28'd0, busy_w}, 32'h0);
        tick();
        chk("conflict_err_drop", {28'd0, err_w}, 32'h0);

        // address wrap, then a read held long past its response
        req(1'b0, 16'h0103, 16'h5555, 4);
        req(1'b1, 16'h0003, 16'h0000, 4);
        req(1'b1, 16'h0103, 16'h0000, 9);

        // backdoor then read at each latency
        load(16'h0005, 16'h1234);
        req(1'b1, 16'h0005, 16'h0000, 4);

        // reset during WAIT of a write: LATENCY=1 committed on its sampling edge
        load(16'h0009, 16'h0009);
        write_m = 1'b1; address = 16'h0009; write_data = 16'hDEAD;
        tick();
        reset_n = 1'b0;
        tick();
        mdl[0][9] = 16'hDEAD;
        chk("midrst_rdy", {28'd0, rdy_w}, 0);
        chk("midrst_ack", {28'd0, ack_w}, 0);
        chk("midrst_busy", {28'd0, busy_w}, 0);
        for (int k = 0; k < N; k++) chk("midrst_rdata", {16'd0, rdat_w[k]}, 0);
        write_m = 1'b0; reset_n = 1'b1;
        tick();
        req(1'b1, 16'h0009, 16'h0000, 4);

        // backdoor ignored while busy, honoured when idle
        ld_addr = 16'h0020; ld_data = 16'h7777;
        req(1'b1, 16'h0020, 16'h0000, 4, 1'b1);
        req(1'b1, 16'h0020, 16'h0000, 4);
        load(16'h0020, 16'h7777);
        req(1'b1, 16'h0020, 16'h0000, 4);

        tick(3);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("L%0d_responses_outstanding", k + 1), exp_q[k].size(), 0);
            chk($sformatf("L%0d_req_error_count", k + 1), err_cnt[k], 1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
